// File: rtl/fetch_unit.sv
// Instruction fetch unit: keeps the PC, issues one instruction-memory request at a time,
// and presents each fetched word to decode under a valid/ready handshake with redirect and flush.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'h0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_sel,
  input  logic [15:0] branch_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] pc;
  logic [15:0] addr_q;
  logic [15:0] pc_next;
  logic        discard;

  logic        start_fetch;
  logic        accept_rsp;
  logic        release_instr;

  assign pc_next = pc_sel ? branch_target : pc + PC_STEP;

  // A redirect always wins, so a response is only captured when nothing is pending or arriving.
  assign start_fetch   = (state == IDLE)  && !pc_sel && !stall;
  assign accept_rsp    = (state == FETCH) && imem_ack && !discard && !pc_sel;
  assign release_instr = (state == HOLD)  && (pc_sel || instr_ready);

  // State register
  // NOTE: sequential state is written with non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_fetch) state_next = FETCH;
      end
      FETCH: begin
        if (imem_ack) state_next = (discard || pc_sel) ? IDLE : HOLD;
      end
      HOLD: begin
        if (release_instr) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req  = (state == FETCH);
    imem_addr = addr_q;
  end

  // PC and request address; while no redirect is pending, pc equals addr_q during FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
    end else begin
      if (pc_sel || accept_rsp) pc <= pc_next;
      if (start_fetch)          addr_q <= pc;
    end
  end

  // Redirect seen while a request is outstanding: the eventual response is stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      discard <= 1'b0;
    end else if (state == FETCH) begin
      if (imem_ack)    discard <= 1'b0;
      else if (pc_sel) discard <= 1'b1;
    end else begin
      discard <= 1'b0;
    end
  end

  // Decode-side instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr       <= 16'h0000;
      instr_pc    <= 16'h0000;
      instr_valid <= 1'b0;
    end else begin
      if (accept_rsp) begin
        instr       <= imem_rdata;
        instr_pc    <= addr_q;
        instr_valid <= 1'b1;
      end else if (release_instr) begin
        instr_valid <= 1'b0;
      end
    end
  end

  // Interface invariants
  a_req_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr)));

  a_single_outstanding : assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_req && instr_valid));

  a_instr_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (instr_valid && !instr_ready && !pc_sel) |=>
      (instr_valid && $stable(instr) && $stable(instr_pc)));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a responding memory model, a scoreboard of expected
// decode outputs, and directed sequences for redirect, backpressure, stall, flush, reset and PC wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, pc_sel, stall, imem_req, imem_ack, instr_valid, instr_ready;
  logic [15:0] branch_target, imem_addr, imem_rdata, instr, instr_pc;

  logic        w_rst_n, w_pc_sel, w_stall, w_imem_req, w_imem_ack, w_instr_valid, w_instr_ready;
  logic [15:0] w_branch_target, w_imem_addr, w_imem_rdata, w_instr, w_instr_pc;

  fetch_unit #(.RESET_PC(16'h0000), .PC_STEP(16'h0001)) dut (
    .clk(clk), .rst_n(rst_n), .pc_sel(pc_sel), .branch_target(branch_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  fetch_unit #(.RESET_PC(16'hFFFF), .PC_STEP(16'h0001)) dut_wrap (
    .clk(clk), .rst_n(w_rst_n), .pc_sel(w_pc_sel), .branch_target(w_branch_target), .stall(w_stall),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(w_imem_ack), .imem_rdata(w_imem_rdata),
    .instr(w_instr), .instr_pc(w_instr_pc), .instr_valid(w_instr_valid), .instr_ready(w_instr_ready)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] word;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp     = 0;
  int   n_bad     = 0;
  int   n_hs      = 0;
  int   n_overlap = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decode side: every accepted instruction is popped and compared against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && imem_req && instr_valid) n_overlap++;
    if (rst_n && instr_valid && instr_ready) begin
      n_hs++;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_pc", {16'h0, instr_pc}, 64'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_pc", instr_pc, e.pc);
        check("sb_instr", instr, e.word);
      end
    end
  end

  task automatic wait_req(input string tag, input logic [15:0] exp_addr);
    int n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req"}, imem_req, 1);
    check({tag, "_addr"}, imem_addr, exp_addr);
  endtask

  // Answers the outstanding request after 'delay' cycles with 16'hA000+address.
  task automatic serve(input string tag, input logic [15:0] addr, input int delay, input bit push);
    exp_t e;
    for (int i = 1; i < delay; i++) begin
      tick();
      check({tag, "_hold"}, {imem_req, imem_addr}, {1'b1, addr});
    end
    imem_ack   = 1'b1;
    imem_rdata = 16'hA000 + imem_addr;
    if (push) begin
      e.pc   = addr;
      e.word = 16'hA000 + addr;
      sb_q.push_back(e);
    end
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    check({tag, "_valid"}, instr_valid, 1);
    check({tag, "_req_low"}, imem_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; pc_sel = 1'b0; branch_target = 16'h0; stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = 16'h0; instr_ready = 1'b1;
    w_rst_n = 1'b1; w_pc_sel = 1'b0; w_branch_target = 16'h0; w_stall = 1'b1;
    w_imem_ack = 1'b0; w_imem_rdata = 16'h0; w_instr_ready = 1'b1;
    #1;
    rst_n = 1'b0; w_rst_n = 1'b0;
    #1;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 16'h0000);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 16'h0000);
    check("rst_instr_pc", instr_pc, 16'h0000);
    check("rst_wrap_addr", w_imem_addr, 16'hFFFF);

    tick();
    rst_n = 1'b1; w_rst_n = 1'b1;
    tick();
    check("rst_to_req", imem_req, 1);

    // Sequential fetch with one-cycle memory latency
    for (int i = 0; i < 3; i++) begin
      wait_req($sformatf("seq%0d", i), 16'(i));
      serve($sformatf("seq%0d", i), 16'(i), 1, 1'b1);
    end

    // Redirect while the fetch of 0003 is outstanding; its response must be dropped
    wait_req("redir", 16'h0003);
    pc_sel = 1'b1; branch_target = 16'h0100;
    tick();
    pc_sel = 1'b0;
    check("redir_hold", {imem_req, imem_addr}, {1'b1, 16'h0003});
    imem_ack = 1'b1; imem_rdata = 16'hA003;
    tick();
    imem_ack = 1'b0;
    check("redir_drop", instr_valid, 0);
    check("redir_idle", imem_req, 0);
    wait_req("redir_tgt", 16'h0100);
    serve("redir_tgt", 16'h0100, 1, 1'b1);
    tick();

    // Backpressure, then stall across the handshake
    instr_ready = 1'b0;
    wait_req("bp", 16'h0101);
    serve("bp", 16'h0101, 2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_stable%0d", i), {instr_valid, imem_req, instr_pc, instr},
            {1'b1, 1'b0, 16'h0101, 16'hA101});
    end
    instr_ready = 1'b1; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall_noreq%0d", i), imem_req, 0);
    end
    stall = 1'b0;
    tick();
    check("stall_release", {imem_req, imem_addr}, {1'b1, 16'h0102});
    serve("post_stall", 16'h0102, 1, 1'b1);
    tick();

    // Flush of a held instruction that decode has not accepted
    instr_ready = 1'b0;
    wait_req("flush_pre", 16'h0103);
    serve("flush_pre", 16'h0103, 1, 1'b0);
    pc_sel = 1'b1; branch_target = 16'h0200;
    tick();
    pc_sel = 1'b0;
    check("flush_valid", instr_valid, 0);
    instr_ready = 1'b1;
    wait_req("flush_tgt", 16'h0200);
    serve("flush_tgt", 16'h0200, 1, 1'b1);
    tick();

    // Reset in the middle of an outstanding request, followed by a late ack
    wait_req("rstmid", 16'h0201);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_req", imem_req, 0);
    check("rstmid_addr", imem_addr, 16'h0000);
    check("rstmid_valid", instr_valid, 0);
    stall = 1'b1;
    tick();
    rst_n = 1'b1;
    imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    tick();
    imem_ack = 1'b0;
    check("late_ack_valid", instr_valid, 0);
    check("late_ack_req", imem_req, 0);
    stall = 1'b0;
    wait_req("after_rst", 16'h0000);
    serve("after_rst", 16'h0000, 1, 1'b1);
    tick();

    // PC wrap on the instance reset to 16'hFFFF
    w_stall = 1'b0;
    for (int n = 0; n < 20 && !w_imem_req; n++) tick();
    check("wrap_req", w_imem_req, 1);
    check("wrap_addr0", w_imem_addr, 16'hFFFF);
    w_imem_ack = 1'b1; w_imem_rdata = 16'hA000 + w_imem_addr;
    tick();
    w_imem_ack = 1'b0;
    check("wrap_instr_pc", w_instr_pc, 16'hFFFF);
    check("wrap_instr", w_instr, 16'h9FFF);
    check("wrap_valid", w_instr_valid, 1);
    tick();
    for (int n = 0; n < 20 && !w_imem_req; n++) tick();
    check("wrap_addr1", {w_imem_req, w_imem_addr}, {1'b1, 16'h0000});

    tick();
    check("sb_drained", sb_q.size(), 0);
    check("handshakes", n_hs, 8);
    check("no_overlap", n_overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded by reset.
REQ-002 Parameter PC_STEP, default 16'h0001: sequential PC increment.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pc_sel  input  1  redirect select: 1 = take branch_target, 0 = sequential PC.
REQ-006 branch_target  input  16  redirect address, sampled when pc_sel=1.
REQ-007 stall  input  1  1 = hold PC and block start of a new fetch.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  16  request address.
REQ-010 imem_ack  input  1  memory response strobe, one cycle per request.
REQ-011 imem_rdata  input  16  instruction word, valid when imem_ack=1.
REQ-012 instr  output  16  fetched instruction to decode.
REQ-013 instr_pc  output  16  address of instr.
REQ-014 instr_valid  output  1  instr/instr_pc hold a valid instruction.
REQ-015 instr_ready  input  1  decode accepts instr when instr_valid=1.

Function
REQ-016 The block SHALL implement states IDLE, FETCH, HOLD plus internal flag discard and registers pc and addr_q (16 bits each).
REQ-017 pc_next SHALL be branch_target when pc_sel=1, else pc+PC_STEP modulo 2^16 (16'hFFFF+1 = 16'h0000).
REQ-018 imem_req SHALL equal (state==FETCH); imem_addr SHALL equal addr_q.
REQ-019 IDLE: if pc_sel=1, pc<=branch_target and stay IDLE; else if stall=0, addr_q<=pc and go FETCH; else stay IDLE with pc unchanged.
REQ-020 FETCH: imem_req and imem_addr SHALL stay stable until imem_ack=1; stall SHALL NOT abort an outstanding request.
REQ-021 FETCH with imem_ack=1, discard=0, pc_sel=0: instr<=imem_rdata, instr_pc<=addr_q, instr_valid<=1, pc<=addr_q+PC_STEP, go HOLD.
REQ-022 FETCH with pc_sel=1 and no ack: pc<=branch_target, discard<=1, stay FETCH; a later pc_sel=1 SHALL overwrite pc with the newest target.
REQ-023 FETCH with imem_ack=1 and (discard=1 or pc_sel=1): response SHALL be dropped (instr_valid stays 0), discard<=0, go IDLE; if pc_sel=1, pc<=branch_target.
REQ-024 HOLD: instr, instr_pc, instr_valid SHALL hold until instr_valid=1 and instr_ready=1 at a clock edge; then instr_valid<=0, go IDLE.
REQ-025 HOLD with pc_sel=1: instr_valid<=0 (flush, regardless of instr_ready), pc<=branch_target, go IDLE.
REQ-026 pc_sel SHALL take priority over stall, sequential increment and instruction capture in every state.
REQ-027 imem_ack in IDLE or HOLD SHALL be ignored.
REQ-028 Minimum latency: reset release to imem_req=1 is one cycle; imem_ack to instr_valid=1 is one cycle; at most one request outstanding.

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE, pc=RESET_PC, addr_q=RESET_PC, discard=0, imem_req=0, imem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0.
REQ-030 Reset asserted mid-request SHALL abandon it; a following imem_ack SHALL be ignored per REQ-027.

Verification
REQ-031 Sequential: reset release, ack each request one cycle later with data 16'hA000+addr, instr_ready=1 -> instr_pc sequence 0000,0001,0002 with instr A000,A001,A002; imem_req never high while instr_valid=1.
REQ-032 Redirect in flight: pc_sel=1, branch_target=16'h0100 during FETCH of 16'h0003, ack two cycles later -> that response dropped, next imem_addr=16'h0100, instr_pc=16'h0100.
REQ-033 Backpressure and stall: instr_ready=0 for 5 cycles -> instr/instr_pc stable, no request; then ready=1 with stall=1 for 3 cycles -> no new imem_req until stall=0, pc unchanged.
REQ-034 Wrap: RESET_PC=16'hFFFF -> first instr_pc=16'hFFFF, next imem_addr=16'h0000.
REQ-035 Flush and reset: pc_sel=1 (target 16'h0200) in HOLD with instr_ready=0 -> instr_valid=0 next cycle, next fetch 16'h0200; rst_n=0 mid-FETCH -> outputs at reset values immediately, late imem_ack produces no instr_valid.
